// File: rtl/scie_pkg.sv
// Shared definitions for the SCIE complex-FIR MAC unit: opcodes, FSM states
// and the saturation helper.
package scie_pkg;

  localparam logic [6:0] OP_LOAD  = 7'h0B;
  localparam logic [6:0] OP_PUSH  = 7'h2B;
  localparam logic [6:0] OP_READ  = 7'h5B;
  localparam logic [6:0] OP_CLEAR = 7'h7B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_e;

  // Working width for the range check; must exceed any accumulator width used.
  localparam int unsigned SAT_W = 512;

  // Classifies a sign-extended value against the signed range of a w-bit word.
  function automatic sat_e sat_check(input logic signed [SAT_W-1:0] v,
                                     input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/scie_cmul.sv
// Combinational complex multiplier: four full-width products, two adders.
module scie_cmul #(
  parameter int unsigned DATA_W = 64
) (
  input  logic signed [DATA_W-1:0] i_a_re,
  input  logic signed [DATA_W-1:0] i_a_im,
  input  logic signed [DATA_W-1:0] i_b_re,
  input  logic signed [DATA_W-1:0] i_b_im,
  output logic signed [2*DATA_W:0] o_re,
  output logic signed [2*DATA_W:0] o_im
);

  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  logic signed [2*DATA_W-1:0] w_rr;
  logic signed [2*DATA_W-1:0] w_ii;
  logic signed [2*DATA_W-1:0] w_ri;
  logic signed [2*DATA_W-1:0] w_ir;

  assign w_rr = i_a_re * i_b_re;
  assign w_ii = i_a_im * i_b_im;
  assign w_ri = i_a_re * i_b_im;
  assign w_ir = i_a_im * i_b_re;

  // One extra bit so the sum/difference of two full products cannot overflow.
  assign o_re = PROD_W'(w_rr) - PROD_W'(w_ii);
  assign o_im = PROD_W'(w_ri) + PROD_W'(w_ir);

endmodule

// File: rtl/scie_cfir_mac.sv
// SCIE complex-FIR custom-instruction unit: TAPS-deep complex delay line,
// one-tap-per-cycle MAC, wrap or saturating result, ready/read-valid handshake.
module scie_cfir_mac
  import scie_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_valid,
  output logic              io_ready,
  input  logic [31:0]       io_insn,
  input  logic [DATA_W-1:0] io_rs1_real,
  input  logic [DATA_W-1:0] io_rs1_imag,
  input  logic [31:0]       io_rs2,
  output logic              io_rd_valid,
  output logic [DATA_W-1:0] io_rd_real,
  output logic [DATA_W-1:0] io_rd_imag
);

  localparam int unsigned PROD_W = 2 * DATA_W + 1;
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(TAPS) + 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  cplx_t                   r_coef [TAPS];
  cplx_t                   r_x    [TAPS];
  cplx_t                   r_res;
  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [IDX_W-1:0]        r_tap;
  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic                    r_sat;
  logic                    r_rd_valid;

  logic [6:0]               w_op;
  logic                     w_sat_mode;
  logic                     w_accept;
  logic                     w_load_ok;
  logic                     w_push;
  logic                     w_read;
  logic                     w_clear;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_prod_re;
  logic signed [PROD_W-1:0] w_prod_im;
  cplx_t                    w_in;
  cplx_t                    w_res;
  logic                     w_unused_insn;

  assign w_op       = io_insn[6:0];
  assign w_sat_mode = io_insn[12];
  assign w_in       = '{re: io_rs1_real, im: io_rs1_imag};

  assign io_ready   = (r_state == ST_IDLE);
  assign w_accept   = io_valid && io_ready;
  // Comparing the whole rs2 word rejects both out-of-range and high-bit aliases.
  assign w_load_ok  = w_accept && (w_op == OP_LOAD) && (io_rs2 < 32'(TAPS));
  assign w_push     = w_accept && (w_op == OP_PUSH);
  assign w_read     = w_accept && (w_op == OP_READ);
  assign w_clear    = w_accept && (w_op == OP_CLEAR);
  assign w_last     = (r_tap == IDX_W'(TAPS - 1));

  assign w_unused_insn = ^{io_insn[31:15], io_insn[14:13], io_insn[11:7]};

  scie_cmul #(
    .DATA_W (DATA_W)
  ) u_cmul (
    .i_a_re (r_coef[r_tap].re),
    .i_a_im (r_coef[r_tap].im),
    .i_b_re (r_x[r_tap].re),
    .i_b_im (r_x[r_tap].im),
    .o_re   (w_prod_re),
    .o_im   (w_prod_im)
  );

  function automatic logic [DATA_W-1:0] to_out(input logic signed [ACC_W-1:0] acc,
                                               input logic sat);
    logic [DATA_W-1:0] v;
    v = acc[DATA_W-1:0];
    if (sat) begin
      unique case (sat_check(SAT_W'(acc), DATA_W))
        SAT_HI:  v = {1'b0, {(DATA_W-1){1'b1}}};
        SAT_LO:  v = {1'b1, {(DATA_W-1){1'b0}}};
        default: v = acc[DATA_W-1:0];
      endcase
    end
    return v;
  endfunction

  always_comb begin
    w_res.re = to_out(r_acc_re, r_sat);
    w_res.im = to_out(r_acc_im, r_sat);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_push) w_state_nxt = ST_MAC;
      ST_MAC:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tap      <= '0;
      r_acc_re   <= '0;
      r_acc_im   <= '0;
      r_sat      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_res      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_read;
      if (w_push) begin
        r_tap    <= '0;
        r_acc_re <= '0;
        r_acc_im <= '0;
        r_sat    <= w_sat_mode;
      end else if (r_state == ST_MAC) begin
        r_tap    <= r_tap + 1'b1;
        r_acc_re <= r_acc_re + ACC_W'(w_prod_re);
        r_acc_im <= r_acc_im + ACC_W'(w_prod_im);
      end
      if (w_clear) begin
        r_res <= '0;
      end else if (r_state == ST_DONE) begin
        r_res <= w_res;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_coef[k] <= '0;
      end
    end else if (w_load_ok) begin
      r_coef[io_rs2[IDX_W-1:0]] <= w_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
    end else if (w_clear) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
    end else if (w_push) begin
      r_x[0] <= w_in;
      for (int unsigned k = 1; k < TAPS; k++) begin
        r_x[k] <= r_x[k-1];
      end
    end
  end

  assign io_rd_valid = r_rd_valid;
  assign io_rd_real  = r_res.re;
  assign io_rd_imag  = r_res.im;

endmodule

// File: tb/tb_scie_cfir_mac.sv
// Directed-vector bench for scie_cfir_mac (TAPS=5, DATA_W=64).
module tb_scie_cfir_mac;

  localparam int unsigned DW = 64;
  localparam logic [6:0] L = 7'h0B;
  localparam logic [6:0] P = 7'h2B;
  localparam logic [6:0] R = 7'h5B;
  localparam logic [6:0] C = 7'h7B;

  localparam logic [63:0] M1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG5 = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] P62  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] N62  = 64'hC000_0000_0000_0000;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_valid = 1'b0;
  logic          io_ready;
  logic [31:0]   io_insn = '0;
  logic [DW-1:0] io_rs1_real = '0;
  logic [DW-1:0] io_rs1_imag = '0;
  logic [31:0]   io_rs2 = '0;
  logic          io_rd_valid;
  logic [DW-1:0] io_rd_real;
  logic [DW-1:0] io_rd_imag;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  scie_cfir_mac #(
    .DATA_W (64),
    .TAPS   (5),
    .IDX_W  (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_valid    (io_valid),
    .io_ready    (io_ready),
    .io_insn     (io_insn),
    .io_rs1_real (io_rs1_real),
    .io_rs1_imag (io_rs1_imag),
    .io_rs2      (io_rs2),
    .io_rd_valid (io_rd_valid),
    .io_rd_real  (io_rd_real),
    .io_rd_imag  (io_rd_imag)
  );

  typedef struct {
    logic [6:0]  op;
    logic        f3;
    logic [63:0] re;
    logic [63:0] im;
    logic [31:0] rs2;
    logic [63:0] ere;
    logic [63:0] eim;
  } vec_t;

  function automatic vec_t v(input logic [6:0] op, input logic f3,
                             input logic [63:0] re, input logic [63:0] im,
                             input logic [31:0] rs2,
                             input logic [63:0] ere, input logic [63:0] eim);
    vec_t t;
    t.op = op; t.f3 = f3; t.re = re; t.im = im; t.rs2 = rs2; t.ere = ere; t.eim = eim;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic f3, input logic [63:0] re,
                       input logic [63:0] im, input logic [31:0] rs2);
    int n = 0;
    @(negedge clock);
    io_valid    = 1'b1;
    io_insn     = {17'd0, 2'b00, f3, 5'd0, op};
    io_rs1_real = re;
    io_rs1_imag = im;
    io_rs2      = rs2;
    while (!io_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!io_ready) chk("issue_timeout", 64'd0, 64'd1);
    @(negedge clock);
    io_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!io_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!io_ready) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_read(input string nm, input logic [63:0] ere, input logic [63:0] eim);
    issue(R, 1'b0, '0, '0, '0);
    chk({nm, "_valid"}, 64'(io_rd_valid), 64'd1);
    chk({nm, "_re"}, io_rd_real, ere);
    chk({nm, "_im"}, io_rd_imag, eim);
    @(negedge clock);
    chk({nm, "_strobe"}, 64'(io_rd_valid), 64'd0);
  endtask

  initial begin
    vec_t tb[$];
    int   cnt;
    int   n;

    tb.push_back(v(L, 0, 64'd1, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(P, 0, 64'd3, 64'd4, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, 64'd3, 64'd4));
    tb.push_back(v(L, 0, 64'd2, 64'd0, 32'd1, 0, 0));
    tb.push_back(v(P, 0, 64'd5, M1, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, 64'd11, 64'd7));
    tb.push_back(v(C, 0, 0, 0, 0, 0, 0));
    tb.push_back(v(L, 0, 64'd1, 64'd2, 32'd0, 0, 0));
    tb.push_back(v(L, 0, 64'd0, 64'd0, 32'd1, 0, 0));
    tb.push_back(v(P, 0, 64'd3, 64'd4, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, NEG5, 64'd10));
    tb.push_back(v(L, 0, P62, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(P, 1, 64'd4, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, MAXP, 64'd0));
    tb.push_back(v(P, 0, 64'd4, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, 64'd0, 64'd0));
    // index guards: rs2=8 aliases c0 and 0x10000001 aliases c1 if unguarded
    tb.push_back(v(C, 0, 0, 0, 0, 0, 0));
    tb.push_back(v(L, 0, 64'd99, 64'd0, 32'd8, 0, 0));
    tb.push_back(v(L, 0, 64'd55, 64'd0, 32'd5, 0, 0));
    tb.push_back(v(L, 0, 64'd33, 64'd0, 32'h1000_0001, 0, 0));
    tb.push_back(v(P, 0, 64'd1, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, P62, 64'd0));
    tb.push_back(v(P, 0, 64'd2, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, MINN, 64'd0));
    tb.push_back(v(L, 0, N62, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(P, 1, 64'd4, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, MINN, 64'd0));
    // last tap: sample must travel to x[4] to meet c4
    tb.push_back(v(C, 0, 0, 0, 0, 0, 0));
    tb.push_back(v(L, 0, 64'd0, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(L, 0, 64'd1, 64'd1, 32'd4, 0, 0));
    tb.push_back(v(P, 0, 64'd2, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(P, 0, 64'd0, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(P, 0, 64'd0, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(P, 0, 64'd0, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, 64'd0, 64'd0));
    tb.push_back(v(P, 0, 64'd0, 64'd0, 32'd0, 0, 0));
    tb.push_back(v(R, 0, 0, 0, 0, 64'd2, 64'd2));

    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(io_ready), 64'd1);
    chk("rst_rdvalid", 64'(io_rd_valid), 64'd0);
    chk("rst_re", io_rd_real, 64'd0);
    chk("rst_im", io_rd_imag, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < tb.size(); i++) begin
      if (tb[i].op == R) begin
        do_read($sformatf("vec%0d", i), tb[i].ere, tb[i].eim);
      end else begin
        issue(tb[i].op, tb[i].f3, tb[i].re, tb[i].im, tb[i].rs2);
        if (tb[i].op == P) wait_idle();
      end
    end

    // Busy window: LOAD c0=9 offered while io_ready is low must be dropped.
    issue(C, 0, '0, '0, '0);
    issue(L, 0, 64'd0, 64'd0, 32'd4);
    issue(L, 0, 64'd1, 64'd0, 32'd0);
    issue(P, 0, 64'd7, 64'd0, 32'd0);
    io_valid    = 1'b1;
    io_insn     = {25'd0, L};
    io_rs1_real = 64'd9;
    io_rs1_imag = 64'd0;
    io_rs2      = 32'd0;
    cnt = 0;
    n   = 0;
    while (!io_ready && n < 20) begin
      cnt++;
      n++;
      if (cnt == 3) io_valid = 1'b0;
      @(negedge clock);
    end
    io_valid = 1'b0;
    chk("busy_cycles", 64'(cnt), 64'd6);
    do_read("busy", 64'd7, 64'd0);

    // Reset two cycles into a MAC.
    issue(P, 0, 64'd5, 64'd0, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_ready", 64'(io_ready), 64'd1);
    chk("midrst_re", io_rd_real, 64'd0);
    chk("midrst_im", io_rd_imag, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_hold_re", io_rd_real, 64'd0);
    do_read("midrst", 64'd0, 64'd0);
    issue(P, 0, 64'd3, 64'd0, 32'd0);
    wait_idle();
    do_read("postrst", 64'd0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
